// File: rtl/elastic_pipe.sv
// Elastic pipeline: a chain of STAGES skid slices, each able to hold two words.
// Define ELASTIC_PIPE_STALL_CNT_EN to enable the output stall counter.

module skid_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] dn_data,
    output logic                  skid_vld
);

    logic [DATA_WIDTH-1:0] skid_q;
    logic                  take;
    logic                  give;

    // up_ready doubles as the "skid register empty" flag
    assign take     = up_valid && up_ready;
    assign give     = dn_valid && dn_ready;
    assign skid_vld = !up_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dn_valid <= 1'b0;
            up_ready <= 1'b1;
        end else if (flush) begin
            dn_valid <= 1'b0;
            up_ready <= 1'b1;
        end else if (give) begin
            if (!up_ready) begin
                up_ready <= 1'b1;
            end else if (!take) begin
                dn_valid <= 1'b0;
            end
        end else if (take) begin
            if (dn_valid) begin
                up_ready <= 1'b0;
            end else begin
                dn_valid <= 1'b1;
            end
        end
    end

    // Payload registers are never cleared; they only move on transfers
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (give) begin
                if (!up_ready) begin
                    dn_data <= skid_q;
                end else if (take) begin
                    dn_data <= up_data;
                end
            end else if (take) begin
                if (dn_valid) begin
                    skid_q <= up_data;
                end else begin
                    dn_data <= up_data;
                end
            end
        end
    end

endmodule

module elastic_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [$clog2(2*STAGES+1)-1:0]    occupancy,
    output logic [15:0]                      stall_cnt
);

    localparam int OCC_W = $clog2(2*STAGES+1);

    logic [STAGES:0]                 vld;
    logic [STAGES:0]                 rdy;
    logic [STAGES:0][DATA_WIDTH-1:0] dat;
    logic [STAGES-1:0]               skid_v;
    logic [OCC_W-1:0]                occ_sum;

    assign vld[0]      = in_valid;
    assign dat[0]      = in_data;
    assign rdy[STAGES] = out_ready;

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES];
    assign out_data  = dat[STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        skid_stage #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .flush    (flush),
            .up_valid (vld[i]),
            .up_ready (rdy[i]),
            .up_data  (dat[i]),
            .dn_valid (vld[i+1]),
            .dn_ready (rdy[i+1]),
            .dn_data  (dat[i+1]),
            .skid_vld (skid_v[i])
        );
    end

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_sum = occ_sum + OCC_W'(vld[i+1]) + OCC_W'(skid_v[i]);
        end
    end

    assign occupancy = occ_sum;

`ifdef ELASTIC_PIPE_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (flush) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed bench for elastic_pipe: a two-slice 32-bit instance and a
// one-slice 8-bit instance driven by the same handshake inputs.

module tb_elastic_pipe;

`ifdef ELASTIC_PIPE_STALL_CNT_EN
    localparam int STALL2 = 10;
    localparam int STALL1 = 11;
`else
    localparam int STALL2 = 0;
    localparam int STALL1 = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_data8;

    logic        p2_in_ready, p2_out_valid;
    logic [31:0] p2_out_data;
    logic [2:0]  p2_occ;
    logic [15:0] p2_stall;

    logic        p1_in_ready, p1_out_valid;
    logic [7:0]  p1_out_data;
    logic [1:0]  p1_occ;
    logic [15:0] p1_stall;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] q2[$];
    logic [7:0]  q1[$];

    assign in_data8 = in_data[7:0];

    always #5 clk = ~clk;

    elastic_pipe #(.DATA_WIDTH(32), .STAGES(2)) u_p2 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(p2_in_ready), .in_data(in_data),
        .out_valid(p2_out_valid), .out_ready(out_ready),
        .out_data(p2_out_data), .occupancy(p2_occ), .stall_cnt(p2_stall)
    );

    elastic_pipe #(.DATA_WIDTH(8), .STAGES(1)) u_p1 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(p1_in_ready), .in_data(in_data8),
        .out_valid(p1_out_valid), .out_ready(out_ready),
        .out_data(p1_out_data), .occupancy(p1_occ), .stall_cnt(p1_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_p2_occ"}, 32'(p2_occ), 0);
        chk({tag, "_p2_ov"}, 32'(p2_out_valid), 0);
        chk({tag, "_p2_ir"}, 32'(p2_in_ready), 1);
        chk({tag, "_p1_occ"}, 32'(p1_occ), 0);
        chk({tag, "_p1_ov"}, 32'(p1_out_valid), 0);
        chk({tag, "_p1_ir"}, 32'(p1_in_ready), 1);
    endtask

    initial begin
        logic acc;
        logic acc1;
        logic em1;
        logic [31:0] e2;
        logic [7:0]  e1;

        // asynchronous reset, checked before any clock edge
        #2 reset_n = 1'b0;
        #1;
        chk_idle("rst");
        chk("rst_p2_stall", 32'(p2_stall), 0);
        chk("rst_p1_stall", 32'(p1_stall), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // single word latency, accepted at first edge after reset
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA5;
        tick();
        in_valid = 1'b0;
        chk("lat_p1_ov", 32'(p1_out_valid), 1);
        chk("lat_p1_od", 32'(p1_out_data), 32'hA5);
        chk("lat_p1_occ", 32'(p1_occ), 1);
        chk("lat_p2_ov0", 32'(p2_out_valid), 0);
        chk("lat_p2_occ", 32'(p2_occ), 1);
        tick();
        chk("lat_p1_occ0", 32'(p1_occ), 0);
        chk("lat_p2_ov", 32'(p2_out_valid), 1);
        chk("lat_p2_od", 32'(p2_out_data), 32'hA5);
        tick();
        chk("lat_p2_occ0", 32'(p2_occ), 0);

        // fill with downstream blocked: capacity is four words
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k);
            tick();
            if (k == 4) begin
                chk("fill_ir", 32'(p2_in_ready), 0);
                chk("fill_occ", 32'(p2_occ), 4);
            end
        end
        chk("fill_occ5", 32'(p2_occ), 4);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk("drain_ov", 32'(p2_out_valid), 1);
            chk("drain_od", p2_out_data, 32'(k));
            acc = in_valid && p2_in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        chk("drain_end_ov", 32'(p2_out_valid), 0);
        chk("drain_end_occ", 32'(p2_occ), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // flush beats a simultaneous offer
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h10 + 32'(k);
            tick();
        end
        in_valid = 1'b0;
        chk("fl_occ3", 32'(p2_occ), 3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h77;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_idle("fl");
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fl_no77", 32'(p2_out_valid), 0);
        end

        // stall counter, then reset in the middle of the stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        tick();
        in_valid = 1'b0;
        tick();
        chk("st_ov", 32'(p2_out_valid), 1);
        chk("st_cnt0", 32'(p2_stall), 0);
        repeat (10) tick();
        chk("st_p2_cnt", 32'(p2_stall), STALL2);
        chk("st_p1_cnt", 32'(p1_stall), STALL1);
        #2 reset_n = 1'b0;
        #1;
        chk_idle("st_rst");
        chk("st_rst_p2_cnt", 32'(p2_stall), 0);
        chk("st_rst_p1_cnt", 32'(p1_stall), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // full throughput stream
        out_ready = 1'b1;
        for (int c = 0; c < 42; c++) begin
            in_valid = (c < 40);
            in_data  = 32'd100 + 32'(c);
            if (c < 40) chk("tp_ir", 32'(p2_in_ready), 1);
            tick();
            if (c < 40) begin
                chk("tp_p1_od", 32'(p1_out_data), 32'((100 + c) & 8'hFF));
            end
            if (c >= 1 && c <= 40) begin
                chk("tp_p2_ov", 32'(p2_out_valid), 1);
                chk("tp_p2_od", p2_out_data, 32'd99 + 32'(c));
            end
        end
        chk("tp_end_ov", 32'(p2_out_valid), 0);

        // random handshakes against queue scoreboards
        for (int c = 0; c < 2000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            acc  = in_valid && p2_in_ready;
            acc1 = in_valid && p1_in_ready;
            em1  = p1_out_valid && out_ready;
            if (p2_out_valid && out_ready) begin
                e2 = (q2.size() > 0) ? q2.pop_front() : 32'hDEAD_BEEF;
                chk("rnd_p2_od", p2_out_data, e2);
            end
            if (em1) begin
                e1 = (q1.size() > 0) ? q1.pop_front() : 8'hEE;
                chk("rnd_p1_od", 32'(p1_out_data), 32'(e1));
            end
            if (acc) q2.push_back(in_data);
            if (acc1) q1.push_back(in_data8);
            tick();
            chk("rnd_p2_occ", 32'(p2_occ), 32'(q2.size()));
            chk("rnd_p1_occ", 32'(p1_occ), 32'(q1.size()));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/elastic_pipe.md
ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width in bits, legal range 1..1024.
REQ-002 Parameter STAGES, default 2: number of cascaded skid slices, legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous clear of all buffered entries.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block can accept a word; driven directly from a flop.
REQ-008 in_data  input  DATA_WIDTH  upstream payload.
REQ-009 out_valid  output  1  output word present; driven directly from a flop.
REQ-010 out_ready  input  1  downstream accepts.
REQ-011 out_data  output  DATA_WIDTH  output payload; driven directly from a flop.
REQ-012 occupancy  output  $clog2(2*STAGES+1)  number of valid entries held.
REQ-013 stall_cnt  output  16  count of output-stall cycles (see Configuration).

Function
REQ-014 The block SHALL be a chain of STAGES skid slices, each holding a main register and a skid register, each with its own valid bit.
REQ-015 Each slice SHALL be in one of three states: EMPTY (main and skid invalid), BUSY (main valid, skid invalid), FULL (main and skid valid).
REQ-016 A slice SHALL assert its upstream ready iff its skid register is invalid (EMPTY or BUSY), computed from registered state only.
REQ-017 Transfer into a slice occurs on a rising edge where its upstream valid and ready are both 1; transfer out occurs where its main valid and downstream ready are both 1.
REQ-018 EMPTY + in: load main, go BUSY.
REQ-019 BUSY + in + no out: load skid, go FULL.
REQ-020 BUSY + in + out: load main with new word, stay BUSY.
REQ-021 BUSY + out + no in: go EMPTY.
REQ-022 FULL + out: main takes skid contents, skid invalidated, go BUSY; no input is possible in FULL.
REQ-023 Words SHALL leave in acceptance order with no loss or duplication.
REQ-024 Latency: with all slices EMPTY and out_ready=1, a word accepted at edge k SHALL appear on out_valid/out_data after edge k+STAGES-1 (i.e. visible in the cycle following edge k for STAGES=1).
REQ-025 Throughput: with out_ready held 1, the block SHALL accept and emit one word per cycle indefinitely.
REQ-026 Maximum storage SHALL be 2*STAGES words; in_ready SHALL be 0 only when the first slice is FULL.
REQ-027 occupancy SHALL equal the total number of valid main and skid registers, updated each edge.
REQ-028 flush=1 at an edge SHALL invalidate every register (occupancy 0, out_valid 0, in_ready 1 next cycle) and SHALL take priority over any simultaneous transfer; a word offered during the flush cycle is discarded.
REQ-029 Data registers SHALL load only on a transfer; they are not cleared by reset or flush.

Reset
REQ-030 While reset_n=0: all valid bits 0, out_valid=0, in_ready=1, occupancy=0, stall_cnt=0, independent of clk.
REQ-031 Reset asserted mid-transfer SHALL discard all held words; first acceptance possible at the first rising edge after reset_n deassertion.

Configuration
REQ-032 Macro ELASTIC_PIPE_STALL_CNT_EN defined: stall_cnt SHALL increment on each edge where out_valid=1 and out_ready=0, saturate at 16'hFFFF, and clear on reset or flush.
REQ-033 Macro not defined: stall_cnt SHALL be constant 0 and no counter logic exists.

Verification
REQ-034 STAGES=1, empty, out_ready=1: send 0xA5 at edge 1 -> out_valid=1, out_data=0xA5 after edge 1; out_ready=1 then occupancy returns to 0 after edge 2.
REQ-035 STAGES=2, out_ready=0: push 1,2,3,4,5 -> first four accepted, in_ready=0 after edge 4, occupancy=4; release out_ready -> output sequence 1,2,3,4 then 5, no gaps after first word.
REQ-036 STAGES=3, out_ready=1, in_valid=1 for 100 cycles of incrementing data -> 100 words out in order, one per cycle, first after STAGES-1 edges following first acceptance.
REQ-037 Occupancy 3, flush=1 with in_valid=1, in_data=0x77 -> next cycle occupancy=0, out_valid=0, 0x77 never emitted.
REQ-038 With ELASTIC_PIPE_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=10; reset_n pulse mid-stall -> stall_cnt=0, occupancy=0 immediately.
REQ-039 Random valid/ready (50% each) for 10,000 cycles, DATA_WIDTH=8, STAGES=4 -> scoreboard order match, occupancy never exceeds 8.
